// File: rtl/sin_mult_pipe_pkg.sv
// Shared widths and Q-format for the sine source and the sample scaler.
// Keeps generator and multiplier in agreement on sample/coef layout.
package sin_mult_pipe_pkg;
   localparam int SM_DATA_W = 22;
   localparam int SM_COEF_W = 16;
   localparam int SM_OUT_W  = 22;
   localparam int SM_SHIFT  = SM_COEF_W - 1;
   localparam int SM_CNT_W  = 16;

   function automatic logic [SM_CNT_W-1:0] sat_inc(
      input logic [SM_CNT_W-1:0] c
   );
      return (&c) ? c : c + SM_CNT_W'(1);
   endfunction
endpackage

// File: rtl/sin_mult_pipe_round_sat.sv
// Shift, round-half-up and clamp of a full signed product.
// Purely combinational; the caller decides where it sits in the pipe.
module round_sat
   import sin_mult_pipe_pkg::*;
#(
   parameter int IN_W  = SM_DATA_W + SM_COEF_W,
   parameter int OUT_W = SM_OUT_W,
   parameter int SHIFT = SM_SHIFT,
   parameter int ROUND = 1,
   parameter int SAT   = 1
) (
   input  logic [IN_W-1:0]  p_in,
   output logic [OUT_W-1:0] r_out,
   output logic             sat
);
   localparam int W  = IN_W + 1;
   localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [W-1:0] RC =
      (ROUND != 0 && SHIFT > 0) ? (W'(1) << RS) : '0;
   localparam logic [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};

   logic signed [W-1:0] sum;
   logic signed [W-1:0] r;
   logic                ovf;

   // one guard bit so the rounding add never overflows
   assign sum = $signed({p_in[IN_W-1], p_in}) + $signed(RC);
   assign r   = sum >>> SHIFT;
   assign ovf = r[W-1:OUT_W-1] != {(W-OUT_W+1){r[W-1]}};

   always_comb begin
      r_out = r[OUT_W-1:0];
      sat   = 1'b0;
      if (SAT != 0 && ovf) begin
         r_out = r[W-1] ? MINV : MAXV;
         sat   = 1'b1;
      end
   end
endmodule

// File: rtl/sin_mult_pipe.sv
// Pipelined signed sample x coefficient scaler with round/saturate,
// valid/ready flow control and a sticky saturation event counter.
module sin_mult_pipe
   import sin_mult_pipe_pkg::*;
#(
   parameter int DATA_W = SM_DATA_W,
   parameter int COEF_W = SM_COEF_W,
   parameter int OUT_W  = SM_OUT_W,
   parameter int SHIFT  = SM_SHIFT,
   parameter int ROUND  = 1,
   parameter int SAT    = 1,
   parameter int PIPE   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in,
   input  logic [COEF_W-1:0] coef_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  data_out,
   output logic              sat_flag,
   output logic [15:0]       sat_count,
   input  logic              clr_count
);
   localparam int P_W = DATA_W + COEF_W;
   localparam int NP  = (PIPE > 2) ? PIPE - 2 : 1;

   logic                     adv;
   logic                     v1;
   logic signed [DATA_W-1:0] a_q;
   logic signed [COEF_W-1:0] b_q;
   logic signed [P_W-1:0]    prod;
   logic [P_W-1:0]           rs_in;
   logic                     rs_v;
   logic [OUT_W-1:0]         rs_out;
   logic                     rs_sat;

   // single global stall: every stage moves together
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) v1 <= 1'b0;
      else if (adv) v1 <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         a_q <= data_in;
         b_q <= coef_in;
      end
   end

   assign prod = P_W'(a_q) * P_W'(b_q);

   if (PIPE == 2) begin : g_comb
      assign rs_in = prod;
      assign rs_v  = v1;
   end else begin : g_reg
      logic [P_W-1:0] p_q [NP];
      logic [NP-1:0]  pv_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) pv_q <= '0;
         else if (adv) begin
            pv_q[0] <= v1;
            for (int i = 1; i < NP; i++) pv_q[i] <= pv_q[i-1];
         end
      end

      always_ff @(posedge clk) begin
         if (adv) begin
            p_q[0] <= prod;
            for (int i = 1; i < NP; i++) p_q[i] <= p_q[i-1];
         end
      end

      assign rs_in = p_q[NP-1];
      assign rs_v  = pv_q[NP-1];
   end

   round_sat #(
      .IN_W  (P_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT),
      .ROUND (ROUND),
      .SAT   (SAT)
   ) u_rs (
      .p_in  (rs_in),
      .r_out (rs_out),
      .sat   (rs_sat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         data_out  <= '0;
         sat_flag  <= 1'b0;
      end else if (adv) begin
         out_valid <= rs_v;
         data_out  <= rs_out;
         sat_flag  <= rs_sat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sat_count <= '0;
      else if (clr_count) sat_count <= '0;
      else if (out_valid & out_ready & sat_flag)
         sat_count <= sat_inc(sat_count);
   end
endmodule
